// File: rtl/window_streamer_if.sv
// Window RAM read port plus the streamed-sample output handshake of window_streamer.
// master = streamer side, slave = RAM/consumer side.
interface window_streamer_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic [ADDR_W-1:0] out_idx;

  modport master (
    output rd_addr, rd_en, out_data, out_valid, out_last, out_idx,
    input  rd_data, out_ready
  );

  modport slave (
    input  rd_addr, rd_en, out_data, out_valid, out_last, out_idx,
    output rd_data, out_ready
  );
endinterface

// File: rtl/window_streamer.sv
// Streams one SAMPLE_SIZE frame out of a sliding-window RAM, oldest sample first.
// Define OFFSET_BINARY_EN to convert offset-binary samples to two's complement on the way out.
module window_streamer #(
  parameter int SAMPLE_SIZE = 4096,
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_process,
  input  logic [ADDR_W-1:0] wr_idx,
  output logic              busy,
  output logic              req_drop,
  window_streamer_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SAMPLE_SIZE - 1);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  function automatic logic [DATA_W-1:0] to_out(input logic [DATA_W-1:0] d);
`ifdef OFFSET_BINARY_EN
    return {~d[DATA_W-1], d[DATA_W-2:0]};
`else
    return d;
`endif
  endfunction

  // Assert asynchronously, release on a single clock edge for every flop.
  logic [1:0] rst_sync;
  logic       rst_int;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int = rst_sync[1];

  state_t            state;
  logic              rd_en_p0;
  logic [ADDR_W-1:0] rd_addr_p0;
  logic [ADDR_W-1:0] rd_k;
  logic              vld_p1;
  logic [DATA_W-1:0] buf_mem [2];
  logic              wp, rp;
  logic [1:0]        cnt;
  logic [ADDR_W-1:0] idx;

  logic              valid, bypass, xfer, push, pop, issue;
  logic [1:0]        cnt_nxt;
  logic [DATA_W-1:0] head;

  // The RAM word arriving this cycle is presented directly when the buffer is empty,
  // so the read latency costs no throughput; it is parked only if not accepted.
  always_comb begin
    valid   = (cnt != 2'd0) || vld_p1;
    bypass  = (cnt == 2'd0) && vld_p1;
    head    = (cnt != 2'd0) ? buf_mem[rp] : bus.rd_data;
    xfer    = valid && bus.out_ready;
    pop     = xfer && (cnt != 2'd0);
    push    = vld_p1 && !(bypass && bus.out_ready);
    cnt_nxt = cnt + 2'(push) - 2'(pop);
    issue   = (cnt_nxt + 2'(rd_en_p0)) < 2'd2;
  end

  assign bus.rd_en     = rd_en_p0;
  assign bus.rd_addr   = rd_addr_p0;
  assign bus.out_valid = valid;
  assign bus.out_data  = valid ? to_out(head) : '0;
  assign bus.out_idx   = idx;
  assign bus.out_last  = valid && (idx == LAST_IDX);
  assign busy          = (state != IDLE);
  assign req_drop      = enable_process && busy;

  // Stage p0: read issue / frame control; stage p1: returning RAM data and output buffer.
  always_ff @(posedge clk or negedge rst_int) begin
    if (!rst_int) begin
      state      <= IDLE;
      rd_en_p0   <= 1'b0;
      rd_addr_p0 <= '0;
      rd_k       <= '0;
      vld_p1     <= 1'b0;
      cnt        <= 2'd0;
      wp         <= 1'b0;
      rp         <= 1'b0;
      idx        <= '0;
    end else begin
      vld_p1 <= rd_en_p0;
      cnt    <= cnt_nxt;
      if (push) wp <= ~wp;
      if (pop)  rp <= ~rp;
      if (xfer) idx <= idx + 1'b1;

      case (state)
        IDLE: begin
          rd_en_p0 <= 1'b0;
          if (enable_process) begin
            state      <= STREAM;
            rd_en_p0   <= 1'b1;
            rd_addr_p0 <= wr_idx;
            rd_k       <= '0;
            idx        <= '0;
          end
        end
        STREAM: begin
          if (issue) begin
            rd_en_p0   <= 1'b1;
            rd_addr_p0 <= rd_addr_p0 + 1'b1;
            rd_k       <= rd_k + 1'b1;
            if (rd_k == LAST_IDX - 1'b1) state <= FLUSH;
          end else begin
            rd_en_p0 <= 1'b0;
          end
        end
        FLUSH: begin
          rd_en_p0 <= 1'b0;
          if (xfer && bus.out_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) buf_mem[wp] <= bus.rd_data;
  end

endmodule

// File: tb/tb_window_streamer.sv
// Scoreboard bench for window_streamer: frame expectations are queued at request time
// and a negedge monitor pops and compares every read strobe and every output transfer.
module tb_window_streamer;
  localparam int N  = 4096;
  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable_process = 1'b0;
  logic [AW-1:0] wr_idx = '0;
  logic          busy, req_drop;

  window_streamer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  window_streamer #(.SAMPLE_SIZE(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .enable_process(enable_process),
    .wr_idx(wr_idx), .busy(busy), .req_drop(req_drop), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [N];
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= ram[bus.rd_addr];

  typedef struct {
    logic [DW-1:0] d;
    int            idx;
    bit            last;
  } exp_t;

  exp_t          exp_q[$];
  logic [AW-1:0] addr_q[$];
  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int started = 0, done = 0, aborted = 0;
  int rd_cnt = 0, first_cyc = 0, last_cyc = 0, req_cyc = 0;
  bit rand_ready = 0, rand_wr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit model_busy();
    return started != (done + aborted);
  endfunction

  function automatic logic [DW-1:0] model_conv(input logic [DW-1:0] d);
`ifdef OFFSET_BINARY_EN
    return d ^ 16'h8000;
`else
    return d;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: read strobes, transfers, stall stability, busy and req_drop.
  bit            held = 0;
  logic [DW-1:0] h_d;
  logic [AW-1:0] h_i;
  logic          h_l;

  always @(negedge clk) begin
    if (!rst_n) begin
      held = 0;
    end else begin
      if (held) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_hold", {h_i, h_l, h_d}, {bus.out_idx, bus.out_last, bus.out_data});
      end
      held = bus.out_valid && !bus.out_ready;
      h_d = bus.out_data; h_i = bus.out_idx; h_l = bus.out_last;

      if (bus.rd_en) begin
        rd_cnt++;
        if (addr_q.size() == 0) fail_now("extra_rd_en");
        else check("rd_addr", bus.rd_addr, addr_q.pop_front());
      end

      check("busy", busy, model_busy());
      check("req_drop", req_drop, enable_process && model_busy());

      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("extra_transfer");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_data", bus.out_data, e.d);
          check("out_idx", bus.out_idx, e.idx);
          check("out_last", bus.out_last, e.last);
          if (e.idx == 0) first_cyc = cyc;
          if (e.last) begin
            last_cyc = cyc;
            done++;
          end
        end
      end
    end
  end

  // All driver tasks start and end at posedge+1 so inputs never move near a sample point.
  task automatic step();
    @(posedge clk); #1;
    if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    if (rand_wr) wr_idx = AW'($urandom);
  endtask

  task automatic request(input logic [AW-1:0] base);
    for (int k = 0; k < N; k++) begin
      exp_q.push_back('{model_conv(ram[(int'(base) + k) % N]), k, k == N - 1});
      addr_q.push_back(AW'((int'(base) + k) % N));
    end
    wr_idx = base;
    enable_process = 1'b1;
    @(posedge clk); #1;
    enable_process = 1'b0;
    started++;
    req_cyc = cyc;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (model_busy() && n < 20000) begin
      step();
      n++;
    end
    if (model_busy()) begin
      fail_now("frame_timeout");
      aborted++;
    end
  endtask

  task automatic wait_idx(input int target);
    int n = 0;
    while (bus.out_idx != AW'(target) && n < 20000) begin
      step();
      n++;
    end
    if (bus.out_idx != AW'(target)) fail_now("wait_idx_timeout");
  endtask

  task automatic run_frame(input logic [AW-1:0] base, input bit timing);
    int rd0;
    rd0 = rd_cnt;
    request(base);
    wait_idle();
    check("rd_en_count", rd_cnt - rd0, N);
    check("exp_q_empty", exp_q.size(), 0);
    check("addr_q_empty", addr_q.size(), 0);
    if (timing) begin
      check("first_latency", first_cyc, req_cyc + 1);
      check("frame_span", last_cyc - first_cyc, N - 1);
    end
  endtask

  task automatic chk_reset();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_rd_en", bus.rd_en, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_req_drop", req_drop, 0);
    check("rst_out_idx", bus.out_idx, 0);
    check("rst_rd_addr", bus.rd_addr, 0);
    check("rst_out_data", bus.out_data, 0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) ram[i] = DW'($urandom);
  endtask

  initial begin
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset();
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Identity RAM, base 0, continuous accept.
    for (int i = 0; i < N; i++) ram[i] = DW'(i);
`ifdef OFFSET_BINARY_EN
    ram[0] = 16'h8000;
    ram[1] = 16'h0000;
`endif
    run_frame(AW'(0), 1);

    // Base captured at 4090 while wr_idx keeps moving; addresses wrap past all-ones.
    fill_random();
    rand_wr = 1;
    run_frame(AW'(4090), 1);
    rand_wr = 0;

    // Random backpressure.
    fill_random();
    rand_ready = 1;
    run_frame(AW'($urandom), 0);
    rand_ready = 0;
    bus.out_ready = 1'b1;
    step();

    // Request mid-frame is dropped; a request right after the last transfer is taken.
    fill_random();
    begin
      int rd0;
      logic [AW-1:0] b;
      b = AW'($urandom);
      rd0 = rd_cnt;
      request(b);
      wait_idx(100);
      enable_process = 1'b1;
      step();
      enable_process = 1'b0;
      wait_idle();
      check("drop_frame_rd_count", rd_cnt - rd0, N);
      check("drop_frame_span", last_cyc - first_cyc, N - 1);
    end
    run_frame(AW'($urandom), 1);

    // Reset in the middle of a frame, then a fresh frame with a new base.
    fill_random();
    request(AW'($urandom));
    wait_idx(2000);
    rst_n = 1'b0;
    #1;
    chk_reset();
    aborted++;
    exp_q.delete();
    addr_q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk_reset();
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    fill_random();
    run_frame(AW'($urandom), 1);

    repeat (4) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
